// File: rtl/poly_addsub_engine.sv
// Self-sequencing polynomial add/subtract engine: streams A and B, writes R = A +/- B, reports trimmed degree.
// Define MODQ_REDUCE_EN to reduce results modulo Q; otherwise results wrap modulo 2^CW.
module poly_addsub_engine #(
    parameter int CW = 26,
    parameter int AW = 11,
    parameter int Q  = 4591
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] degA,
    input  logic [AW-1:0] degB,
    output logic          rd_en_a,
    output logic          rd_en_b,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    input  logic [CW-1:0] rd_data_a,
    input  logic [CW-1:0] rd_data_b,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [CW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] deg_out,
    output logic          zero_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    r_state;
    logic          r_mode;
    logic [AW-1:0] r_degA;
    logic [AW-1:0] r_degB;
    logic [AW:0]   r_n;
    logic [AW:0]   r_k;
    logic [1:0]    r_drain;
    logic          r_s1ValA;
    logic          r_s1ValB;
    logic [AW-1:0] r_s1Addr;
    logic [AW-1:0] r_trk;
    logic          r_nz;

    logic [AW-1:0] w_maxDeg;
    logic [CW-1:0] w_a;
    logic [CW-1:0] w_b;
    logic          w_s1Valid;
    logic [CW-1:0] w_result;

    assign w_maxDeg  = (degA > degB) ? degA : degB;
    assign w_a       = r_s1ValA ? rd_data_a : '0;
    assign w_b       = r_s1ValB ? rd_data_b : '0;
    assign w_s1Valid = r_s1ValA | r_s1ValB;

`ifdef MODQ_REDUCE_EN
    localparam logic [CW:0] QW = (CW+1)'(Q);

    logic [CW:0] w_sum;
    logic [CW:0] w_sumRed;
    logic [CW:0] w_diffWrap;

    assign w_sum      = {1'b0, w_a} + {1'b0, w_b};
    assign w_sumRed   = w_sum - QW;
    assign w_diffWrap = {1'b0, w_a} + QW - {1'b0, w_b};

    always_comb begin
        w_result = '0;
        if (r_mode) begin
            w_result = (w_a < w_b) ? w_diffWrap[CW-1:0] : (w_a - w_b);
        end else begin
            w_result = (w_sum >= QW) ? w_sumRed[CW-1:0] : w_sum[CW-1:0];
        end
    end
`else
    always_comb begin
        w_result = r_mode ? (w_a - w_b) : (w_a + w_b);
    end
`endif

    // Issue counter runs one cycle ahead of the read strobes; the stage-1 flags follow the strobes by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_degA    <= '0;
            r_degB    <= '0;
            r_n       <= '0;
            r_k       <= '0;
            r_drain   <= '0;
            r_s1ValA  <= 1'b0;
            r_s1ValB  <= 1'b0;
            r_s1Addr  <= '0;
            r_trk     <= '0;
            r_nz      <= 1'b0;
            rd_en_a   <= 1'b0;
            rd_en_b   <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            deg_out   <= '0;
            zero_out  <= 1'b0;
        end else begin
            done     <= 1'b0;
            r_s1ValA <= rd_en_a;
            r_s1ValB <= rd_en_b;
            r_s1Addr <= rd_addr_a;
            wr_en    <= w_s1Valid;
            if (w_s1Valid) begin
                wr_addr <= r_s1Addr;
                wr_data <= w_result;
                if (w_result != '0) begin
                    r_trk <= r_s1Addr;
                    r_nz  <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    rd_en_a <= 1'b0;
                    rd_en_b <= 1'b0;
                    if (start) begin
                        r_mode    <= mode;
                        r_degA    <= degA;
                        r_degB    <= degB;
                        r_n       <= {1'b0, w_maxDeg} + (AW+1)'(1);
                        r_k       <= (AW+1)'(1);
                        rd_en_a   <= 1'b1;
                        rd_en_b   <= 1'b1;
                        rd_addr_a <= '0;
                        rd_addr_b <= '0;
                        r_trk     <= '0;
                        r_nz      <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_k == r_n) begin
                        rd_en_a <= 1'b0;
                        rd_en_b <= 1'b0;
                        r_drain <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        rd_en_a   <= (r_k <= {1'b0, r_degA});
                        rd_en_b   <= (r_k <= {1'b0, r_degB});
                        rd_addr_a <= r_k[AW-1:0];
                        rd_addr_b <= r_k[AW-1:0];
                        r_k       <= r_k + (AW+1)'(1);
                    end
                end
                S_DRAIN: begin
                    r_drain <= r_drain + 2'd1;
                    // Stay out of IDLE for the done cycle so a start there is not accepted.
                    if (r_drain == 2'd1) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        deg_out  <= r_trk;
                        zero_out <= !r_nz;
                    end else if (r_drain == 2'd2) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_addsub_engine.sv
// Self-checking bench for poly_addsub_engine: directed table, protocol sequences and randomized runs vs a reference model.
module tb_poly_addsub_engine;

    localparam int CW    = 26;
    localparam int AW    = 11;
    localparam int Q     = 4591;
    localparam int DEPTH = 1 << AW;
    localparam longint MASK = (longint'(1) << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          mode;
    logic [AW-1:0] degA;
    logic [AW-1:0] degB;
    logic          rd_en_a;
    logic          rd_en_b;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [CW-1:0] rd_data_a;
    logic [CW-1:0] rd_data_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic [AW-1:0] deg_out;
    logic          zero_out;

    int memA [DEPTH];
    int memB [DEPTH];
    int expR [DEPTH];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit m;
        int dA;
        int dB;
        int a [3];
        int b [3];
        int eMod [3];
        int eRaw [3];
        int eDeg;
        bit eZero;
    } vec_t;

    vec_t vecs [6];

    poly_addsub_engine #(.CW(CW), .AW(AW), .Q(Q)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .degA(degA), .degB(degB),
        .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .deg_out(deg_out), .zero_out(zero_out)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories; unread cycles return all-ones so a missing operand mask shows up.
    always @(posedge clk) begin
        rd_data_a <= rd_en_a ? CW'(memA[rd_addr_a]) : {CW{1'b1}};
        rd_data_b <= rd_en_b ? CW'(memB[rd_addr_b]) : {CW{1'b1}};
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic longint refCoef(input bit m, input longint a, input longint b);
`ifdef MODQ_REDUCE_EN
        return m ? ((a - b + Q) % Q) : ((a + b) % Q);
`else
        return m ? ((a - b) & MASK) : ((a + b) & MASK);
`endif
    endfunction

    function automatic int randCoef();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 0;
        if (sel == 1) return Q - 1;
        return $urandom_range(0, Q - 1);
    endfunction

    task automatic fillMem();
        for (int i = 0; i < DEPTH; i++) begin
            memA[i] = randCoef();
            memB[i] = randCoef();
        end
    endtask

    task automatic buildExpected(input bit m, input int dA, input int dB, output int eDeg, output bit eZero);
        int n;
        longint a;
        longint b;
        n = ((dA > dB) ? dA : dB) + 1;
        eDeg  = 0;
        eZero = 1'b1;
        for (int k = 0; k < n; k++) begin
            a = (k <= dA) ? memA[k] : 0;
            b = (k <= dB) ? memB[k] : 0;
            expR[k] = int'(refCoef(m, a, b));
            if (expR[k] != 0) begin
                eDeg  = k;
                eZero = 1'b0;
            end
        end
    endtask

    task automatic addVec(input int idx, input bit m, input int dA, input int dB,
                          input int a0, input int a1, input int a2,
                          input int b0, input int b1, input int b2,
                          input int e0, input int e1, input int e2,
                          input int r0, input int r1, input int r2,
                          input int eDeg, input bit eZero);
        vecs[idx].m = m;
        vecs[idx].dA = dA;
        vecs[idx].dB = dB;
        vecs[idx].a[0] = a0; vecs[idx].a[1] = a1; vecs[idx].a[2] = a2;
        vecs[idx].b[0] = b0; vecs[idx].b[1] = b1; vecs[idx].b[2] = b2;
        vecs[idx].eMod[0] = e0; vecs[idx].eMod[1] = e1; vecs[idx].eMod[2] = e2;
        vecs[idx].eRaw[0] = r0; vecs[idx].eRaw[1] = r1; vecs[idx].eRaw[2] = r2;
        vecs[idx].eDeg = eDeg;
        vecs[idx].eZero = eZero;
    endtask

    // One complete run, checked cycle by cycle against the documented timeline (cycle 0 = start cycle).
    task automatic applyStimulus(input string tag, input bit m, input int dA, input int dB,
                                 input int eDeg, input bit eZero,
                                 input int restartCycle, input bit startAtDone);
        int  n;
        bit  expRdA;
        bit  expRdB;
        bit  expWr;
        n = ((dA > dB) ? dA : dB) + 1;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        degA  = AW'(dA);
        degB  = AW'(dB);
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            start = (c == restartCycle);
            if (c == restartCycle) begin
                mode = ~m;
                degA = '0;
                degB = '0;
            end
            expRdA = (c <= n) && (c - 1 <= dA);
            expRdB = (c <= n) && (c - 1 <= dB);
            expWr  = (c >= 3) && (c <= n + 2);
            checkOutput($sformatf("%s c%0d busy", tag, c), busy, (c <= n + 2));
            checkOutput($sformatf("%s c%0d done", tag, c), done, (c == n + 3));
            checkOutput($sformatf("%s c%0d rd_en_a", tag, c), rd_en_a, expRdA);
            checkOutput($sformatf("%s c%0d rd_en_b", tag, c), rd_en_b, expRdB);
            if (expRdA) checkOutput($sformatf("%s c%0d rd_addr_a", tag, c), rd_addr_a, c - 1);
            if (expRdB) checkOutput($sformatf("%s c%0d rd_addr_b", tag, c), rd_addr_b, c - 1);
            checkOutput($sformatf("%s c%0d wr_en", tag, c), wr_en, expWr);
            if (expWr) begin
                checkOutput($sformatf("%s c%0d wr_addr", tag, c), wr_addr, c - 3);
                checkOutput($sformatf("%s c%0d wr_data", tag, c), wr_data, expR[c - 3]);
            end
            if (c == n + 3) begin
                checkOutput($sformatf("%s deg_out", tag), deg_out, eDeg);
                checkOutput($sformatf("%s zero_out", tag), zero_out, eZero);
                start = startAtDone;
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            checkOutput($sformatf("%s post%0d busy", tag, c), busy, 0);
            checkOutput($sformatf("%s post%0d wr_en", tag, c), wr_en, 0);
            checkOutput($sformatf("%s post%0d rd_en_a", tag, c), rd_en_a, 0);
        end
        checkOutput($sformatf("%s held deg_out", tag), deg_out, eDeg);
        checkOutput($sformatf("%s held zero_out", tag), zero_out, eZero);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " rd_en_a"}, rd_en_a, 0);
        checkOutput({tag, " rd_en_b"}, rd_en_b, 0);
        checkOutput({tag, " rd_addr_a"}, rd_addr_a, 0);
        checkOutput({tag, " rd_addr_b"}, rd_addr_b, 0);
        checkOutput({tag, " wr_en"}, wr_en, 0);
        checkOutput({tag, " wr_addr"}, wr_addr, 0);
        checkOutput({tag, " wr_data"}, wr_data, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " deg_out"}, deg_out, 0);
        checkOutput({tag, " zero_out"}, zero_out, 0);
    endtask

    initial begin
        int  eDeg;
        bit  eZero;
        bit  m;
        int  dA;
        int  dB;

        start = 1'b0;
        mode  = 1'b0;
        degA  = '0;
        degB  = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 checkAllZero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        addVec(0, 1'b0, 2, 1, 10, 20, 30, 5, 4590, 0, 15, 19, 30, 15, 4610, 30, 2, 1'b0);
        addVec(1, 1'b1, 0, 2, 3, 0, 0, 5, 0, 7, 4589, 0, 4584, 67108862, 0, 67108857, 2, 1'b0);
        addVec(2, 1'b1, 2, 2, 1, 2, 3, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        addVec(3, 1'b1, 2, 2, 1, 2, 3, 0, 0, 3, 1, 2, 0, 1, 2, 0, 1, 1'b0);
        addVec(4, 1'b0, 0, 0, 4590, 0, 0, 4590, 0, 0, 4589, 0, 0, 9180, 0, 0, 0, 1'b0);
        addVec(5, 1'b1, 0, 0, 3, 0, 0, 5, 0, 0, 4589, 0, 0, 67108862, 0, 0, 0, 1'b0);

        for (int v = 0; v < 6; v++) begin
            fillMem();
            for (int k = 0; k < 3; k++) begin
                if (k <= vecs[v].dA) memA[k] = vecs[v].a[k];
                if (k <= vecs[v].dB) memB[k] = vecs[v].b[k];
`ifdef MODQ_REDUCE_EN
                expR[k] = vecs[v].eMod[k];
`else
                expR[k] = vecs[v].eRaw[k];
`endif
            end
            applyStimulus($sformatf("vec%0d", v), vecs[v].m, vecs[v].dA, vecs[v].dB,
                          vecs[v].eDeg, vecs[v].eZero, (v == 3) ? 2 : 0, (v == 2));
        end

        // Reset asserted mid-run must clear every output immediately and suppress done.
        fillMem();
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        degA  = AW'(5);
        degB  = AW'(5);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 checkAllZero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("afterreset c%0d done", c), done, 0);
            checkOutput($sformatf("afterreset c%0d wr_en", c), wr_en, 0);
            checkOutput($sformatf("afterreset c%0d busy", c), busy, 0);
        end
        buildExpected(1'b0, 5, 5, eDeg, eZero);
        applyStimulus("postreset", 1'b0, 5, 5, eDeg, eZero, 0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            fillMem();
            m  = 1'($urandom_range(0, 1));
            dA = $urandom_range(0, 40);
            dB = $urandom_range(0, 40);
            if (r % 5 == 0) begin
                m  = 1'b1;
                dB = dA;
                for (int k = 0; k < DEPTH; k++) memB[k] = memA[k];
            end
            buildExpected(m, dA, dB, eDeg, eZero);
            applyStimulus($sformatf("rand%0d", r), m, dA, dB, eDeg, eZero, 0, 1'b0);
        end

        fillMem();
        buildExpected(1'b0, DEPTH - 1, DEPTH - 1, eDeg, eZero);
        applyStimulus("fulldepth", 1'b0, DEPTH - 1, DEPTH - 1, eDeg, eZero, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
